ldpc_llr_loader: RTL and testbench
==================================

# ldpc_llr_loader

Input stage ahead of the LDPC decoder core. Accepts channel LLR samples as a valid/ready stream of W lanes per beat, saturates each sample to the core's signed `data_w` width and assembles full R*D-sample frames. Frames are held in two ping-pong banks, so the next frame can stream in while the core decodes the current one. Presents a complete frame as the parallel `sig` bus the core samples when it starts a new codeword.

## Interface
Parameters:
- `data_w`, 8, LLR width at core side (signed two's complement)
- `in_w`, 10, LLR width at input (signed), `in_w >= data_w`
- `R`, 24, block rows of the code
- `D`, 24, lifting (circulant) size
- `W`, 8, samples per input beat; R*D must be a multiple of W

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  loader can accept a beat
- `in_data`  in  W*in_w  lane k at bits [k*in_w +: in_w]
- `in_last`  in  1  marks final beat of a frame
- `sig`  out  R*D*data_w  frame to core; sample n at [n*data_w +: data_w]
- `sig_valid`  out  1  `sig` holds a complete frame
- `sig_ready`  in  1  core has taken the frame (one-cycle pulse from core control)
- `frm_err`  out  1  sticky framing error
- `frm_cnt`  out  16  frames delivered, wraps at 2^16

## Operation
- BEATS = R*D/W (72 at defaults). Beat b, lane k → sample n = b*W + k.
- Saturation per lane: clamp to symmetric range [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], i.e. ±127 at defaults. −128 is never produced.
- Two banks, each with state EMPTY → FILLING → FULL → EMPTY. Write pointer `wp` and read pointer `rp` are each 1 bit.
- Bank state transitions:
  - EMPTY → FILLING: on the first accepted beat.
  - FILLING → FULL: on an accepted beat with count = BEATS−1 and `in_last` = 1. `wp` toggles and the beat counter clears.
  - FULL → EMPTY: on `sig_valid & sig_ready`. `rp` toggles.
- `in_ready` = bank[`wp`] ≠ FULL. A beat is accepted when `in_valid & in_ready`.
- `sig_valid` = bank[`rp`] == FULL. `sig` is driven from bank[`rp`] and is stable while `sig_valid` is high. When `sig_valid` is low, `sig` is don't-care.
- Framing error: any of the following discards the current frame (bank → EMPTY, count → 0) and sets `frm_err` until reset. `wp` does not move.
  - `in_last` = 1 on an accepted beat with count < BEATS−1.
  - `in_last` = 0 on an accepted beat with count = BEATS−1.
- `frm_cnt` increments on every `sig_valid & sig_ready`.
- A `sig_ready` pulse while `sig_valid` is low is ignored.

## Timing
- Reset values (`rst` = 0 at a clock edge): both banks EMPTY with contents zeroed, `wp` = `rp` = 0, count = 0, `in_ready` = 1 from the first cycle after reset, `sig_valid` = 0, `frm_err` = 0, `frm_cnt` = 0.
- Reset mid-frame discards all partial and full frames.
- Latency: the last beat is accepted at edge t; `sig_valid` = 1 after edge t, with the full frame on `sig`.
- Throughput: one beat per cycle while a bank is free. With both banks FULL, `in_ready` is low until the core frees one.
- Completion and release in the same cycle (fill bank A while bank B is freed) are both applied. `in_ready` rises the following cycle.
- Completing a fill into bank[`rp`] when it was the only EMPTY bank raises `sig_valid` next cycle.

## Structure
- Shared package `ldpc_pkg`: `data_w`, `R`, `D`, `C` defaults, the derived N = R*D, and the bank-state enum {EMPTY, FILLING, FULL}. The core and check stages use the same constants.
- One sub-module `llr_sat` (in_w → data_w symmetric saturator, combinational). It is instantiated W times, once per lane.
- Bank storage is two N*data_w registers, each written W samples per beat at offset count*W.

## Test plan
- Single frame: 72 beats, sample n = n mod 100, `in_last` on beat 71 → `sig_valid` after beat 71 with sample n = n mod 100. Pulse `sig_ready` → `sig_valid` drops and `frm_cnt` = 1.
- Saturation: lane values +300, −300, −128, +127, −127, 0 → 127, −127, −127, 127, −127, 0.
- Back-pressure: stream 3 frames back-to-back with `sig_ready` held low. After the 2nd frame `in_ready` goes low and stays low. One `sig_ready` pulse → `in_ready` high next cycle and the 3rd frame completes. Frames are delivered in order 1, 2, 3.
- Framing errors: `in_last` on beat 10 → `frm_err` = 1, no `sig_valid`, and the next clean frame still loads correctly. Also check a missing `in_last` on beat 71 → same behaviour.
- Simultaneous events: the last beat of bank 1 and `sig_ready` for bank 0 occur on the same edge → bank 0 is EMPTY, bank 1 is FULL, and `sig_valid` stays high, now showing the bank 1 data.
- Reset mid-operation: `rst` low during beat 40 with the other bank FULL → all outputs return to reset values, and a fresh frame then loads normally.

Source files
------------

// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_pkg
//  Description : Constants and types shared by the LDPC loader, core and
//                check stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

    localparam int c_data_w = 8;            // LLR width at the core side
    localparam int c_r      = 24;           // block rows of the code
    localparam int c_d      = 24;           // lifting (circulant) size
    localparam int c_c      = 48;           // block columns of the code
    localparam int c_n      = c_r * c_d;    // samples per frame

    // Life cycle of one ping-pong frame bank
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/llr_sat.sv
`default_nettype none
// ============================================================================
//  Module      : llr_sat
//  Description : Combinational symmetric saturator, signed IN_W -> DATA_W.
//                Output range is +/-(2^(DATA_W-1)-1); the most negative
//                code is never produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module llr_sat #(
    parameter int IN_W   = 10,
    parameter int DATA_W = 8
) (
    input  logic [IN_W-1:0]   i_llr,
    output logic [DATA_W-1:0] o_llr
);

    localparam logic signed [IN_W-1:0] c_max     = IN_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] c_min     = -c_max;
    localparam logic [DATA_W-1:0]      c_max_out = DATA_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic [DATA_W-1:0]      c_min_out = -c_max_out;

    logic signed [IN_W-1:0] w_in;

    assign w_in = $signed(i_llr);

    // Clamp to the symmetric range, otherwise pass the low bits through
    always_comb begin
        o_llr = i_llr[DATA_W-1:0];
        if (w_in > c_max) begin
            o_llr = c_max_out;
        end else if (w_in < c_min) begin
            o_llr = c_min_out;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ldpc_llr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_llr_loader
//  Description : Saturates streamed channel LLRs and assembles them into
//                full frames held in two ping-pong banks; presents the
//                oldest complete frame to the decoder core as a wide bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldpc_llr_loader
    import ldpc_pkg::*;
#(
    parameter int data_w = c_data_w,
    parameter int in_w   = 10,
    parameter int R      = c_r,
    parameter int D      = c_d,
    parameter int W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W*in_w-1:0]       in_data,
    input  logic                    in_last,
    output logic [R*D*data_w-1:0]   sig,
    output logic                    sig_valid,
    input  logic                    sig_ready,
    output logic                    frm_err,
    output logic [15:0]             frm_cnt
);

    localparam int c_frame_n = R * D;
    localparam int c_beats   = c_frame_n / W;
    localparam int c_cnt_w   = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_frm_w   = c_frame_n * data_w;
    localparam int c_beat_w  = W * data_w;
    localparam int c_idx_w   = $clog2(c_frm_w);

    bank_state_t            r_state [2];
    bank_state_t            w_state_nxt [2];
    logic [c_frm_w-1:0]     r_bank [2];
    logic                   r_wp;
    logic                   w_wp_nxt;
    logic                   r_rp;
    logic                   w_rp_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic [15:0]            r_frm_cnt;
    logic [15:0]            w_frm_cnt_nxt;

    logic [c_beat_w-1:0]    w_sat;
    logic [c_idx_w-1:0]     w_base;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_at_end;

    // One saturator per input lane
    for (genvar k = 0; k < W; k++) begin : g_lane
        llr_sat #(
            .IN_W   (in_w),
            .DATA_W (data_w)
        ) u_sat (
            .i_llr (in_data[k*in_w +: in_w]),
            .o_llr (w_sat[k*data_w +: data_w])
        );
    end

    assign in_ready  = (r_state[r_wp] != FULL);
    assign sig_valid = (r_state[r_rp] == FULL);
    assign sig       = r_bank[r_rp];
    assign frm_err   = r_err;
    assign frm_cnt   = r_frm_cnt;

    assign w_accept  = in_valid & in_ready;
    assign w_release = sig_valid & sig_ready;
    assign w_at_end  = (r_cnt == c_cnt_w'(c_beats - 1));
    assign w_base    = c_idx_w'(r_cnt) * c_idx_w'(c_beat_w);

    // Next-state: fill/complete/abort on the write bank, release on the read
    // bank. Both may fire together since they never target the same bank.
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        w_wp_nxt       = r_wp;
        w_rp_nxt       = r_rp;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = r_err;
        w_frm_cnt_nxt  = r_frm_cnt;

        if (w_accept) begin
            if (in_last != w_at_end) begin
                // Early or missing in_last: drop the partial frame
                w_state_nxt[r_wp] = EMPTY;
                w_cnt_nxt         = '0;
                w_err_nxt         = 1'b1;
            end else if (w_at_end) begin
                w_state_nxt[r_wp] = FULL;
                w_wp_nxt          = ~r_wp;
                w_cnt_nxt         = '0;
            end else begin
                w_state_nxt[r_wp] = FILLING;
                w_cnt_nxt         = r_cnt + 1'b1;
            end
        end

        if (w_release) begin
            w_state_nxt[r_rp] = EMPTY;
            w_rp_nxt          = ~r_rp;
            w_frm_cnt_nxt     = r_frm_cnt + 16'd1;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_frm_cnt  <= '0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_wp       <= w_wp_nxt;
            r_rp       <= w_rp_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_frm_cnt  <= w_frm_cnt_nxt;
        end
    end

    // Bank storage: each accepted beat lands at its slot in the write bank
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_accept) begin
            r_bank[r_wp][w_base +: c_beat_w] <= w_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_llr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldpc_llr_loader
//  Description : Directed self-checking bench for ldpc_llr_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldpc_llr_loader;

    localparam int DATA_W = 8;
    localparam int IN_W   = 10;
    localparam int R      = 24;
    localparam int D      = 24;
    localparam int W      = 8;
    localparam int N      = R * D;
    localparam int BEATS  = N / W;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 in_ready;
    logic [W*IN_W-1:0]    in_data   = '0;
    logic                 in_last   = 1'b0;
    logic [N*DATA_W-1:0]  sig;
    logic                 sig_valid;
    logic                 sig_ready = 1'b0;
    logic                 frm_err;
    logic [15:0]          frm_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int sat_in  [W] = '{300, -300, -128, 127, -127, 0, 511, -512};
    int sat_exp [W] = '{127, -127, -127, 127, -127, 0, 127, -127};

    always #5 clk = ~clk;

    ldpc_llr_loader #(
        .data_w (DATA_W),
        .in_w   (IN_W),
        .R      (R),
        .D      (D),
        .W      (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .sig       (sig),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .frm_err   (frm_err),
        .frm_cnt   (frm_cnt)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Beat b of a frame whose sample n carries (n + seed) mod 100
    function automatic logic [W*IN_W-1:0] beat(input int seed, input int b);
        logic [W*IN_W-1:0] d;
        d = '0;
        for (int k = 0; k < W; k++) begin
            d[k*IN_W +: IN_W] = IN_W'((b * W + k + seed) % 100);
        end
        return d;
    endfunction

    // Present one beat and hold it until the loader takes it
    task automatic push(input logic [W*IN_W-1:0] d, input logic last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) begin
            check("push_timeout", 1, 0);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_beats(input int seed, input int from, input int to, input int last_at);
        for (int b = from; b <= to; b++) begin
            push(beat(seed, b), (b == last_at));
        end
    endtask

    task automatic check_frame(input string tag, input int seed, input int first);
        for (int n = first; n < N; n++) begin
            check($sformatf("%s_s%0d", tag, n),
                  int'($signed(sig[n*DATA_W +: DATA_W])), (n + seed) % 100);
        end
    endtask

    task automatic pulse_ready();
        sig_ready = 1'b1;
        @(posedge clk);
        #1;
        sig_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W*IN_W-1:0] d;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_sig_valid", int'(sig_valid), 0);
        check("rst_frm_err", int'(frm_err), 0);
        check("rst_frm_cnt", int'(frm_cnt), 0);

        // Single frame
        send_beats(0, 0, BEATS - 2, -1);
        check("f1_valid_before_last", int'(sig_valid), 0);
        send_beats(0, BEATS - 1, BEATS - 1, BEATS - 1);
        check("f1_valid", int'(sig_valid), 1);
        check_frame("f1", 0, 0);
        pulse_ready();
        check("f1_valid_drop", int'(sig_valid), 0);
        check("f1_frm_cnt", int'(frm_cnt), 1);

        // Saturation on beat 0
        for (int k = 0; k < W; k++) begin
            d[k*IN_W +: IN_W] = IN_W'(sat_in[k]);
        end
        push(d, 1'b0);
        send_beats(0, 1, BEATS - 1, BEATS - 1);
        check("sat_valid", int'(sig_valid), 1);
        for (int k = 0; k < W; k++) begin
            check($sformatf("sat_lane%0d", k),
                  int'($signed(sig[k*DATA_W +: DATA_W])), sat_exp[k]);
        end
        check_frame("sat", 0, W);
        pulse_ready();
        check("sat_frm_cnt", int'(frm_cnt), 2);

        // Early in_last on beat 10
        send_beats(50, 0, 10, 10);
        check("early_err", int'(frm_err), 1);
        check("early_valid", int'(sig_valid), 0);
        check("early_ready", int'(in_ready), 1);
        send_beats(3, 0, BEATS - 1, BEATS - 1);
        check("clean1_valid", int'(sig_valid), 1);
        check_frame("clean1", 3, 0);
        pulse_ready();
        check("clean1_frm_cnt", int'(frm_cnt), 3);

        // Missing in_last on the final beat
        send_beats(60, 0, BEATS - 1, -1);
        check("nolast_valid", int'(sig_valid), 0);
        check("nolast_err", int'(frm_err), 1);
        send_beats(5, 0, BEATS - 1, BEATS - 1);
        check("clean2_valid", int'(sig_valid), 1);
        check_frame("clean2", 5, 0);
        pulse_ready();
        check("clean2_frm_cnt", int'(frm_cnt), 4);

        // Back-pressure: two frames fill both banks, third must wait
        send_beats(11, 0, BEATS - 1, BEATS - 1);
        send_beats(22, 0, BEATS - 1, BEATS - 1);
        check("bp_ready_low", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = beat(44, 0);
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_c%0d", c), int'(in_ready), 0);
        end
        check_frame("bpA", 11, 0);
        pulse_ready();
        check("bp_ready_back", int'(in_ready), 1);
        check("bp_valid_B", int'(sig_valid), 1);
        check_frame("bpB", 22, 0);
        send_beats(44, 0, BEATS - 1, BEATS - 1);
        check("bp_ready_fullagain", int'(in_ready), 0);
        check_frame("bpB_hold", 22, 0);
        pulse_ready();
        check("bp_valid_C", int'(sig_valid), 1);
        check_frame("bpC", 44, 0);
        pulse_ready();
        check("bp_valid_end", int'(sig_valid), 0);
        check("bp_frm_cnt", int'(frm_cnt), 7);

        // Reset during beat 40 while the other bank is full
        send_beats(70, 0, BEATS - 1, BEATS - 1);
        send_beats(80, 0, 39, -1);
        in_valid = 1'b1;
        in_data  = beat(80, 40);
        rst      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        check("mrst_in_ready", int'(in_ready), 1);
        check("mrst_sig_valid", int'(sig_valid), 0);
        check("mrst_frm_err", int'(frm_err), 0);
        check("mrst_frm_cnt", int'(frm_cnt), 0);
        check("mrst_sig_zero", int'(|sig), 0);
        send_beats(9, 0, BEATS - 1, BEATS - 1);
        check("fresh_valid", int'(sig_valid), 1);
        check_frame("fresh", 9, 0);

        // Completion of bank 1 and release of bank 0 on the same edge
        send_beats(17, 0, BEATS - 2, -1);
        sig_ready = 1'b1;
        send_beats(17, BEATS - 1, BEATS - 1, BEATS - 1);
        sig_ready = 1'b0;
        check("sim_valid", int'(sig_valid), 1);
        check("sim_ready", int'(in_ready), 1);
        check("sim_frm_cnt", int'(frm_cnt), 1);
        check_frame("sim", 17, 0);
        pulse_ready();
        check("sim_valid_end", int'(sig_valid), 0);
        check("sim_frm_cnt_end", int'(frm_cnt), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
